idct_8: RTL and testbench

- Pipelined 8-point inverse DCT (DCT-III) over 18-bit signed words; the inverse of the team's 8-point forward transform.
- Accepts one coefficient vector per cycle in the forward block's output word order and returns 8 reconstructed samples in natural order.
- Uses a valid/ready handshake with full backpressure. Sits on the decode/reconstruction side of the transform datapath.

---
 rtl/idct_8.sv | 159 +++++++++++++++
 tb/tb_idct_8.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_8.sv
// idct_8: 4-stage pipelined 8-point inverse DCT (DCT-III) with valid/ready and full backpressure.
// Each coefficient is a Q9 main term plus a small Q15 correction term, so reconstruction stays within 2 LSB.

module idct_8_mul #(
  parameter int W  = 18,
  parameter int CW = 10,
  parameter int AW = 22,
  parameter int A  = 0,
  parameter int B  = 0
) (
  input  logic signed [W-1:0]  x,
  output logic signed [AW-1:0] p
);
  localparam int PW = W + CW + 7;
  localparam logic signed [CW-1:0] CA = CW'(A);
  localparam logic signed [CW-1:0] CB = CW'(B);
  localparam logic signed [PW-1:0] RND = PW'(1 << 14);

  logic signed [W+CW-1:0] pa, pb;
  logic signed [PW-1:0]   acc;

  assign pa  = (W+CW)'(x) * (W+CW)'(CA);
  assign pb  = (W+CW)'(x) * (W+CW)'(CB);
  // x*(A/512 + B/32768), rounded to nearest integer
  assign acc = PW'($signed({pa, 6'd0})) + PW'(pb) + RND;
  assign p   = AW'(acc >>> 15);
endmodule

module idct_8 #(
  parameter int W  = 18,
  parameter int CW = 10,
  parameter int GW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [8*W-1:0] coef_in_flat,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [8*W-1:0] samp_out_flat,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sat_flag
);
  localparam int AW = W + GW;
  localparam int NP = 22;
  // even products: X0*0.5, X4*c4, X2*c2, X2*s2, X6*c2, X6*s2 (input word per product in EV_W)
  localparam int EV_A [6] = '{256, 362, 473, 196, 473, 196};
  localparam int EV_B [6] = '{0, 2, 2, -4, 2, -4};
  localparam int EV_W [6] = '{0, 1, 2, 2, 3, 3};
  // odd coefficients c1, c3, c5, c7
  localparam int OD_A [4] = '{502, 426, 284, 100};
  localparam int OD_B [4] = '{10, -18, 29, -7};
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (W-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

  logic signed [AW-1:0] prod [NP];
  logic signed [AW-1:0] p_q [NP], p_d [NP];
  logic signed [AW-1:0] e_q [4], e_d [4], o_q [4], o_d [4];
  logic signed [AW-1:0] y_q [8], y_d [8];
  logic [8*W-1:0]       samp_q, samp_d;
  logic                 sat_q, sat_d;
  logic [4:1]           vld_q, vld_d;
  logic                 adv1, adv2, adv3, adv4;
  logic signed [AW-1:0] ev_a, ev_b, ev_t0, ev_t1, r;

  for (genvar g = 0; g < 6; g++) begin : g_ev
    idct_8_mul #(.W(W), .CW(CW), .AW(AW), .A(EV_A[g]), .B(EV_B[g])) u_mul (
      .x(coef_in_flat[EV_W[g]*W +: W]), .p(prod[g]));
  end
  // odd product for input X(2j+1) and coefficient c(2q+1) lands at 6 + 4j + q
  for (genvar j = 0; j < 4; j++) begin : g_odj
    for (genvar q = 0; q < 4; q++) begin : g_odq
      idct_8_mul #(.W(W), .CW(CW), .AW(AW), .A(OD_A[q]), .B(OD_B[q])) u_mul (
        .x(coef_in_flat[(4+j)*W +: W]), .p(prod[6+4*j+q]));
    end
  end

  assign adv4      = !vld_q[4] || out_ready;
  assign adv3      = !vld_q[3] || adv4;
  assign adv2      = !vld_q[2] || adv3;
  assign adv1      = !vld_q[1] || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_q[4];
  assign samp_out_flat = samp_q;
  assign sat_flag  = sat_q;

  always_comb begin
    vld_d  = vld_q;
    p_d    = p_q;
    e_d    = e_q;
    o_d    = o_q;
    y_d    = y_q;
    samp_d = samp_q;
    sat_d  = sat_q;
    r      = '0;
    ev_a   = p_q[0] + p_q[1];
    ev_b   = p_q[0] - p_q[1];
    ev_t0  = p_q[2] + p_q[5];
    ev_t1  = p_q[3] - p_q[4];
    if (adv1) begin
      vld_d[1] = in_valid;
      p_d      = prod;
    end
    if (adv2) begin
      vld_d[2] = vld_q[1];
      e_d[0] = ev_a + ev_t0;
      e_d[1] = ev_b + ev_t1;
      e_d[2] = ev_b - ev_t1;
      e_d[3] = ev_a - ev_t0;
      o_d[0] = p_q[6] + p_q[11] + p_q[16] + p_q[21];
      o_d[1] = p_q[7] - p_q[13] - p_q[14] - p_q[20];
      o_d[2] = p_q[8] - p_q[10] + p_q[17] + p_q[19];
      o_d[3] = p_q[9] - p_q[12] + p_q[15] - p_q[18];
    end
    if (adv3) begin
      vld_d[3] = vld_q[2];
      for (int n = 0; n < 4; n++) begin
        y_d[n]   = e_q[n] + o_q[n];
        y_d[7-n] = e_q[n] - o_q[n];
      end
    end
    if (adv4) begin
      vld_d[4] = vld_q[3];
      sat_d    = 1'b0;
      for (int n = 0; n < 8; n++) begin
        r = (y_q[n] + AW'(2)) >>> 2;
        if (r > SMAX) begin
          samp_d[n*W +: W] = SMAX[W-1:0];
          sat_d = 1'b1;
        end else if (r < SMIN) begin
          samp_d[n*W +: W] = SMIN[W-1:0];
          sat_d = 1'b1;
        end else begin
          samp_d[n*W +: W] = r[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      p_q    <= '{default: '0};
      e_q    <= '{default: '0};
      o_q    <= '{default: '0};
      y_q    <= '{default: '0};
      samp_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      p_q    <= p_d;
      e_q    <= e_d;
      o_q    <= o_d;
      y_q    <= y_d;
      samp_q <= samp_d;
      sat_q  <= sat_d;
    end
  end
endmodule

// File: tb/tb_idct_8.sv
// Scoreboard bench for idct_8: directed vectors, backpressure, forward-model round trip, mid-stream reset.
module tb_idct_8;
  localparam int W = 18;
  localparam int ORD [8] = '{0, 4, 2, 6, 1, 3, 5, 7};
  localparam real PI = 3.14159265358979;

  typedef int vec_t [8];
  typedef struct {
    logic [7:0][W-1:0] y;
    int                tol;
    logic [7:0]        mask;
    logic              sat;
  } exp_t;

  logic           clk, reset, in_valid, in_ready, out_valid, out_ready, sat_flag;
  logic [8*W-1:0] coef_in_flat, samp_out_flat;

  exp_t sb [$];
  int   tests = 0, fails = 0, rmode = 1, out_cnt = 0;

  idct_8 dut (
    .clk(clk), .reset(reset), .coef_in_flat(coef_in_flat), .in_valid(in_valid),
    .in_ready(in_ready), .samp_out_flat(samp_out_flat), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_ready changes just after the active edge so handshakes are decided cleanly at the negedge
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(1));
    endcase
  end

  function automatic logic [8*W-1:0] pack(input vec_t X);
    logic [8*W-1:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i*W +: W] = W'(X[ORD[i]]);
    return v;
  endfunction

  function automatic exp_t mke(input vec_t Y, input int tol, input logic [7:0] mask, input logic sat);
    exp_t e;
    for (int i = 0; i < 8; i++) e.y[i] = W'(Y[i]);
    e.tol  = tol;
    e.mask = mask;
    e.sat  = sat;
    return e;
  endfunction

  // monitor: a handshake seen at the negedge completes on the following posedge
  always @(negedge clk) begin : mon
    exp_t e;
    logic signed [W-1:0] a, ex;
    int d, bad;
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output vec %0d: got output, want none", out_cnt);
      end else begin
        e = sb.pop_front();
        bad = -1;
        for (int i = 0; i < 8; i++) begin
          if (e.mask[i]) begin
            a  = samp_out_flat[i*W +: W];
            ex = e.y[i];
            d  = int'(a) - int'(ex);
            if ((d > e.tol || d < -e.tol) && bad < 0) bad = i;
          end
        end
        if (bad >= 0 || sat_flag !== e.sat) begin
          fails++;
          if (bad < 0) bad = 0;
          a  = samp_out_flat[bad*W +: W];
          ex = e.y[bad];
          $display("FAIL output vec %0d word %0d: got %0d want %0d (tol %0d), sat got %0b want %0b",
                   out_cnt, bad, a, ex, e.tol, sat_flag, e.sat);
        end
      end
      out_cnt++;
    end
  end

  task automatic check(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input vec_t X, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    coef_in_flat = pack(X);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 want 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue_empty", 144'(sb.size()), 144'(0));
  endtask

  initial begin : main
    vec_t X, Y, xs;
    logic [8*W-1:0] snap;
    int acc, n;
    real s;
    reset = 1'b1; in_valid = 1'b0; coef_in_flat = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 144'(out_valid), 144'(0));
    check("reset_samp_out", samp_out_flat, '0);
    check("reset_sat_flag", 144'(sat_flag), 144'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", 144'(in_ready), 144'(1));

    // DC, negative DC, single AC, saturation then zero
    X = '{default: 0}; X[0] = 1024;  Y = '{default: 128};
    send(X, mke(Y, 0, 8'hff, 1'b0));
    X[0] = -1024; Y = '{default: -128};
    send(X, mke(Y, 0, 8'hff, 1'b0));
    X = '{default: 0}; X[1] = 1024;
    Y = '{251, 213, 142, 50, -50, -142, -213, -251};
    send(X, mke(Y, 2, 8'hff, 1'b0));
    X = '{default: 131071}; Y = '{default: 0}; Y[0] = 131071;
    send(X, mke(Y, 0, 8'h01, 1'b1));
    X = '{default: 0}; Y = '{default: 0};
    send(X, mke(Y, 0, 8'hff, 1'b0));
    idle();
    drain();

    // backpressure: 6 distinct DC vectors against a stalled output
    rmode = 0;
    repeat (2) @(posedge clk);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      X = '{default: 0}; X[0] = 64 * (acc + 1);
      coef_in_flat = pack(X);
      in_valid = 1'b1;
      if (in_ready && acc < 6) begin
        Y = '{default: 8 * (acc + 1)};
        sb.push_back(mke(Y, 0, 8'hff, 1'b0));
        acc++;
      end
    end
    check("bp_accepted", 144'(acc), 144'(4));
    check("bp_in_ready", 144'(in_ready), 144'(0));
    check("bp_out_valid", 144'(out_valid), 144'(1));
    snap = samp_out_flat;
    repeat (3) @(negedge clk);
    check("bp_hold_valid", 144'(out_valid), 144'(1));
    check("bp_hold_data", samp_out_flat, snap);
    rmode = 1;
    for (int i = 4; i < 6; i++) begin
      X = '{default: 0}; X[0] = 64 * (i + 1); Y = '{default: 8 * (i + 1)};
      send(X, mke(Y, 0, 8'hff, 1'b0));
    end
    idle();
    drain();

    // random round trip through a real-valued forward DCT-II
    rmode = 2;
    for (int v = 0; v < 1000; v++) begin
      for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(4095)) - 2048;
      for (int k = 0; k < 8; k++) begin
        s = 0.0;
        for (int i = 0; i < 8; i++) s = s + xs[i] * $cos((2 * i + 1) * k * PI / 16.0);
        X[k] = int'(s);
      end
      send(X, mke(xs, 2, 8'hff, 1'b0));
    end
    idle();
    drain();

    // reset with three vectors held in the stalled pipe
    rmode = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      X = '{default: 0}; X[0] = 800 + 80 * i; Y = '{default: 100 + 10 * i};
      send(X, mke(Y, 0, 8'hff, 1'b0));
    end
    idle();
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_out_valid", 144'(out_valid), 144'(1));
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", 144'(out_valid), 144'(0));
    check("async_reset_samp_out", samp_out_flat, '0);
    sb.delete();
    rmode = 1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_in_ready", 144'(in_ready), 144'(1));
    @(negedge clk);
    X = '{default: 0}; X[0] = 512; Y = '{default: 64};
    coef_in_flat = pack(X);
    in_valid = 1'b1;
    sb.push_back(mke(Y, 0, 8'hff, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check("post_reset_latency", 144'(n), 144'(4));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
